// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the datapath
// control lines from the current state and the registered instruction class.
// Instruction and data memories use req/ready handshakes. The data access gives up
// after TIMEOUT cycles, sets a sticky bus_error and parks in HALT until reset.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   opcode, func          IR[31:26], IR[5:0] (IR held by the datapath)
//   zero                  ALU equal flag, valid in EXEC
//   imem_ready            instruction word valid this cycle
//   dmem_ready            data access complete this cycle
//   imem_req, ir_we       fetch request, IR load
//   pc_we, nPC_sel        PC update, next-PC select (0 +4, 1 branch, 2 jump, 3 GPR[rs])
//   alu_op                0 add, 1 sub, 2 or, 3 compare, 15 lui
//   reg_dst               0 rt, 1 rd, 2 $31
//   alu_src_a, alu_src_b  A: 0 rs, 1 PC; B: 0 rt, 1 ext imm, 2 constant 4
//   ext_op                0 zero, 1 sign, 2 upper
//   wb_sel, reg_write     write-back source (0 ALU, 1 memory), GPR write enable
//   dmem_req, mem_write   data request, store qualifier
//   illegal               one-cycle pulse on an unsupported encoding
//   bus_error             sticky data-memory timeout flag
//   retired               completed-instruction count (wraps)
//   state                 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 HALT
module multicycle_control #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               ir_we,
   output logic               pc_we,
   output logic [2:0]         nPC_sel,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         reg_dst,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         ext_op,
   output logic               wb_sel,
   output logic               reg_write,
   output logic               dmem_req,
   output logic               mem_write,
   output logic               illegal,
   output logic               bus_error,
   output logic [CNT_W-1:0]   retired,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      ClsIllegal, ClsAddu, ClsSubu, ClsJr, ClsOri, ClsLw,
      ClsSw, ClsBeq, ClsLui, ClsJ, ClsJal
   } cls_e;

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d, dec_cls;
   logic [7:0]       tmo_q, tmo_d;
   logic [8:0]       tmo_inc;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             bus_err_q, bus_err_d;

   assign state     = state_q;
   assign retired   = retired_q;
   assign bus_error = bus_err_q;
   assign tmo_inc   = {1'b0, tmo_q} + 9'd1;

   // Instruction classification from the IR fields.
   always_comb begin
      dec_cls = ClsIllegal;
      case (opcode)
         6'h00: begin
            case (func)
               6'h21:   dec_cls = ClsAddu;
               6'h23:   dec_cls = ClsSubu;
               6'h08:   dec_cls = ClsJr;
               default: dec_cls = ClsIllegal;
            endcase
         end
         6'h0D:   dec_cls = ClsOri;
         6'h23:   dec_cls = ClsLw;
         6'h2B:   dec_cls = ClsSw;
         6'h04:   dec_cls = ClsBeq;
         6'h0F:   dec_cls = ClsLui;
         6'h02:   dec_cls = ClsJ;
         6'h03:   dec_cls = ClsJal;
         default: dec_cls = ClsIllegal;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StFetch;
         cls_q     <= ClsIllegal;
         tmo_q     <= 8'd0;
         retired_q <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         tmo_q     <= tmo_d;
         retired_q <= retired_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      tmo_d     = tmo_q;
      retired_d = retired_q;
      bus_err_d = bus_err_q;
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      nPC_sel   = 3'd0;
      alu_op    = '0;
      reg_dst   = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      ext_op    = 2'd0;
      wb_sel    = 1'b0;
      reg_write = 1'b0;
      dmem_req  = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;

      case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            cls_d = dec_cls;
            if (dec_cls == ClsIllegal) begin
               // Skip the bad word: step PC and refetch without retiring.
               illegal = 1'b1;
               pc_we   = 1'b1;
               state_d = StFetch;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StWb;
            case (cls_q)
               ClsAddu: alu_op = ALUOP_W'(0);
               ClsSubu: alu_op = ALUOP_W'(1);
               ClsOri: begin
                  alu_op    = ALUOP_W'(2);
                  alu_src_b = 2'd1;
               end
               ClsLui: begin
                  alu_op    = ALUOP_W'(15);
                  alu_src_b = 2'd1;
                  ext_op    = 2'd2;
               end
               ClsLw, ClsSw: begin
                  alu_src_b = 2'd1;
                  ext_op    = 2'd1;
                  state_d   = StMem;
               end
               ClsBeq: begin
                  alu_op    = ALUOP_W'(3);
                  pc_we     = 1'b1;
                  nPC_sel   = zero ? 3'd1 : 3'd0;
                  retired_d = retired_q + CNT_W'(1);
                  state_d   = StFetch;
               end
               ClsJal: begin
                  // Link value PC+4 is formed here and written in WB.
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
               end
               ClsJr: begin
                  pc_we     = 1'b1;
                  nPC_sel   = 3'd3;
                  retired_d = retired_q + CNT_W'(1);
                  state_d   = StFetch;
               end
               ClsJ: begin
                  pc_we     = 1'b1;
                  nPC_sel   = 3'd2;
                  retired_d = retired_q + CNT_W'(1);
                  state_d   = StFetch;
               end
               default: state_d = StFetch;
            endcase
         end
         StMem: begin
            dmem_req  = 1'b1;
            mem_write = (cls_q == ClsSw);
            if (dmem_ready) begin
               // Ready wins even on the cycle the wait count would expire.
               tmo_d = 8'd0;
               if (cls_q == ClsSw) begin
                  pc_we     = 1'b1;
                  retired_d = retired_q + CNT_W'(1);
                  state_d   = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (tmo_inc >= 9'(TIMEOUT)) begin
               tmo_d     = 8'd0;
               bus_err_d = 1'b1;
               state_d   = StHalt;
            end else begin
               tmo_d = tmo_inc[7:0];
            end
         end
         StWb: begin
            reg_write = 1'b1;
            pc_we     = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetch;
            case (cls_q)
               ClsAddu, ClsSubu: reg_dst = 2'd1;
               ClsLw:            wb_sel  = 1'b1;
               ClsJal: begin
                  reg_dst = 2'd2;
                  nPC_sel = 3'd2;
               end
               default: reg_dst = 2'd0;
            endcase
         end
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase

      // While reset is held only the fetch request is visible.
      if (!reset_n) begin
         imem_req  = 1'b1;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         nPC_sel   = 3'd0;
         alu_op    = '0;
         reg_dst   = 2'd0;
         alu_src_a = 1'b0;
         alu_src_b = 2'd0;
         ext_op    = 2'd0;
         wb_sel    = 1'b0;
         reg_write = 1'b0;
         dmem_req  = 1'b0;
         mem_write = 1'b0;
         illegal   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;
   localparam int ALUOP_W = 4;

   localparam int K_ILL = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LW = 5;
   localparam int K_SW = 6, K_BEQ = 7, K_LUI = 8, K_J = 9, K_JAL = 10;
   localparam int P_FETCH = 0, P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 7;
   localparam int P_RESET = 8;

   logic clk, reset_n;
   logic [5:0] opcode, func;
   logic zero, imem_ready, dmem_ready;
   logic imem_req, ir_we, pc_we, alu_src_a, wb_sel, reg_write, dmem_req, mem_write;
   logic illegal, bus_error;
   logic [2:0] nPC_sel, state;
   logic [ALUOP_W-1:0] alu_op;
   logic [1:0] reg_dst, alu_src_b, ext_op;
   logic [CNT_W-1:0] retired;

   multicycle_control #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
      .ir_we(ir_we), .pc_we(pc_we), .nPC_sel(nPC_sel), .alu_op(alu_op),
      .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
      .wb_sel(wb_sel), .reg_write(reg_write), .dmem_req(dmem_req), .mem_write(mem_write),
      .illegal(illegal), .bus_error(bus_error), .retired(retired), .state(state)
   );

   typedef struct packed {
      logic [2:0] state;
      logic       imem_req, ir_we, pc_we;
      logic [2:0] npc;
      logic [3:0] alu_op;
      logic [1:0] reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b, ext_op;
      logic       wb_sel, reg_write, dmem_req, mem_write, illegal, bus_error;
   } outs_t;

   localparam int OW = $bits(outs_t);
   logic [OW-1:0] act;
   assign act = {state, imem_req, ir_we, pc_we, nPC_sel, alu_op, reg_dst, alu_src_a,
                 alu_src_b, ext_op, wb_sel, reg_write, dmem_req, mem_write, illegal, bus_error};

   typedef struct {
      logic [5:0] op, fn;
      logic       z;
      int         fw, mw, cyc, ret, regw, ill;
      string      name;
   } vec_t;

   int vectors = 0, miscompares = 0;
   logic [CNT_W-1:0] model_ret;
   bit model_halt;
   logic [2:0] obs_st;
   logic obs_rw, obs_il;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                       (fn == 6'h08) ? K_JR : K_ILL;
         6'h0D: return K_ORI;
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h04: return K_BEQ;
         6'h0F: return K_LUI;
         6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_ILL;
      endcase
   endfunction

   // Required outputs for one cycle of the given phase, with a mask of the
   // fields that are defined for that phase/class.
   task automatic expect_outs(input int ph, input int k, input logic z, input logic ir,
                              input logic dr, output outs_t e, output outs_t m);
      e = '0;
      m = '0;
      m.state = '1; m.imem_req = 1; m.ir_we = 1; m.pc_we = 1; m.reg_write = 1;
      m.dmem_req = 1; m.mem_write = 1; m.illegal = 1; m.bus_error = 1;
      e.bus_error = model_halt;
      case (ph)
         P_RESET: begin
            m = '1;
            e = '0;
            e.imem_req = 1;
         end
         P_FETCH: begin
            e.imem_req = 1;
            e.ir_we = ir;
         end
         P_DEC: begin
            e.state = 3'd1;
            if (k == K_ILL) begin
               e.illegal = 1; e.pc_we = 1; m.npc = '1;
            end
         end
         P_EXEC: begin
            e.state = 3'd2;
            if (!(k == K_JR || k == K_J)) begin
               m.alu_op = '1; m.alu_src_b = '1; m.alu_src_a = 1;
            end
            case (k)
               K_SUBU: e.alu_op = 4'd1;
               K_ORI:  begin e.alu_op = 4'd2; e.alu_src_b = 2'd1; m.ext_op = '1; end
               K_LUI:  begin
                  e.alu_op = 4'd15; e.alu_src_b = 2'd1; e.ext_op = 2'd2; m.ext_op = '1;
               end
               K_LW, K_SW: begin e.alu_src_b = 2'd1; e.ext_op = 2'd1; m.ext_op = '1; end
               K_BEQ: begin
                  e.alu_op = 4'd3; e.pc_we = 1; e.npc = z ? 3'd1 : 3'd0; m.npc = '1;
               end
               K_JAL: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
               K_JR:  begin e.pc_we = 1; e.npc = 3'd3; m.npc = '1; end
               K_J:   begin e.pc_we = 1; e.npc = 3'd2; m.npc = '1; end
               default: ;
            endcase
         end
         P_MEM: begin
            e.state = 3'd3;
            e.dmem_req = 1;
            e.mem_write = (k == K_SW);
            if (dr && k == K_SW) begin
               e.pc_we = 1; m.npc = '1;
            end
         end
         P_WB: begin
            e.state = 3'd4;
            e.reg_write = 1; e.pc_we = 1;
            m.npc = '1; m.reg_dst = '1; m.wb_sel = 1;
            if (k == K_ADDU || k == K_SUBU) e.reg_dst = 2'd1;
            if (k == K_LW) e.wb_sel = 1;
            if (k == K_JAL) begin e.reg_dst = 2'd2; e.npc = 3'd2; end
         end
         P_HALT: e.state = 3'd7;
         default: ;
      endcase
   endtask

   task automatic step(input int ph, input int k, input logic z, input logic ir,
                       input logic dr, input string nm);
      outs_t e, m;
      logic [OW-1:0] ev, mv;
      zero = z; imem_ready = ir; dmem_ready = dr;
      #3;
      expect_outs(ph, k, z, ir, dr, e, m);
      ev = e; mv = m;
      obs_st = state; obs_rw = reg_write; obs_il = illegal;
      vectors++;
      if ((act & mv) !== (ev & mv)) begin
         miscompares++;
         $display("FAIL %s phase=%0d cls=%0d: got %h want %h (mask %h)",
                  nm, ph, k, act & mv, ev & mv, mv);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_ret(input string nm);
      vectors++;
      if (retired !== model_ret) begin
         miscompares++;
         $display("FAIL %s retired: got %0d want %0d", nm, retired, model_ret);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_ret = '0;
      model_halt = 0;
      step(P_RESET, K_ILL, 1'b0, 1'b1, 1'b1, "reset");
      step(P_RESET, K_ILL, 1'b0, 1'b1, 1'b0, "reset");
      check_ret("reset");
      reset_n = 1'b1;
      imem_ready = 1'b0;
   endtask

   // Drives one instruction through its phases as the rules dictate, checking
   // every cycle; reports observed non-FETCH cycles (+1 fetch), writes, illegal pulses.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input string nm,
                            output int cyc, output int regw, output int ill);
      int k;
      k = cls_of(op, fn);
      opcode = op; func = fn;
      cyc = 1; regw = 0; ill = 0;
      for (int i = 0; i < fw; i++) step(P_FETCH, k, z, 1'b0, 1'b0, nm);
      step(P_FETCH, k, z, 1'b1, 1'b0, nm);
      step(P_DEC, k, z, 1'b0, 1'b0, nm);
      cyc += int'(obs_st != 0); ill += int'(obs_il);
      if (k == K_ILL) return;
      step(P_EXEC, k, z, 1'b0, 1'b0, nm);
      cyc += int'(obs_st != 0);
      if (k == K_BEQ || k == K_J || k == K_JR) begin
         model_ret++;
         return;
      end
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i < 1000; i++) begin
            if (i < mw) begin
               step(P_MEM, k, z, 1'b0, 1'b0, nm);
               cyc += int'(obs_st != 0);
               if (i + 1 == TIMEOUT) begin
                  model_halt = 1;
                  return;
               end
            end else begin
               step(P_MEM, k, z, 1'b0, 1'b1, nm);
               cyc += int'(obs_st != 0);
               break;
            end
         end
         if (k == K_SW) begin
            model_ret++;
            return;
         end
      end
      step(P_WB, k, z, 1'b0, 1'b0, nm);
      cyc += int'(obs_st != 0); regw += int'(obs_rw);
      model_ret++;
   endtask

   vec_t tbl[14];

   initial begin
      int cyc, regw, ill, k;
      logic [CNT_W-1:0] r0, dret;
      logic [5:0] op, fn;
      logic [5:0] legal_ops[8];

      tbl[0]  = '{6'h00, 6'h21, 1'b0, 0, 0, 4, 1, 1, 0, "addu"};
      tbl[1]  = '{6'h00, 6'h23, 1'b0, 2, 0, 4, 1, 1, 0, "subu"};
      tbl[2]  = '{6'h0D, 6'h00, 1'b0, 0, 0, 4, 1, 1, 0, "ori"};
      tbl[3]  = '{6'h0F, 6'h00, 1'b1, 1, 0, 4, 1, 1, 0, "lui"};
      tbl[4]  = '{6'h23, 6'h00, 1'b0, 0, 3, 8, 1, 1, 0, "lw_wait3"};
      tbl[5]  = '{6'h2B, 6'h00, 1'b0, 0, 1, 5, 1, 0, 0, "sw_wait1"};
      tbl[6]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3, 1, 0, 0, "beq_taken"};
      tbl[7]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 1, 0, 0, "beq_not"};
      tbl[8]  = '{6'h02, 6'h00, 1'b0, 0, 0, 3, 1, 0, 0, "j"};
      tbl[9]  = '{6'h00, 6'h08, 1'b0, 0, 0, 3, 1, 0, 0, "jr"};
      tbl[10] = '{6'h03, 6'h00, 1'b0, 0, 0, 4, 1, 1, 0, "jal"};
      tbl[11] = '{6'h3F, 6'h00, 1'b0, 0, 0, 2, 0, 0, 1, "op3f"};
      tbl[12] = '{6'h00, 6'h20, 1'b0, 0, 0, 2, 0, 0, 1, "rtype_20"};
      tbl[13] = '{6'h23, 6'h00, 1'b0, 0, 0, 5, 1, 1, 0, "lw_nowait"};
      legal_ops = '{6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03};

      reset_n = 1'b0; opcode = '0; func = '0; zero = 0; imem_ready = 0; dmem_ready = 0;
      model_ret = '0; model_halt = 0;
      #1;
      do_reset();

      // Directed table.
      foreach (tbl[i]) begin
         r0 = retired;
         run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].mw, tbl[i].name,
                   cyc, regw, ill);
         check_ret(tbl[i].name);
         dret = retired - r0;
         vectors += 4;
         if (cyc != tbl[i].cyc) begin
            miscompares++;
            $display("FAIL %s cycles: got %0d want %0d", tbl[i].name, cyc, tbl[i].cyc);
         end
         if (dret != CNT_W'(tbl[i].ret)) begin
            miscompares++;
            $display("FAIL %s retired delta: got %0d want %0d", tbl[i].name, dret,
                     tbl[i].ret);
         end
         if (regw != tbl[i].regw) begin
            miscompares++;
            $display("FAIL %s reg_write: got %0d want %0d", tbl[i].name, regw, tbl[i].regw);
         end
         if (ill != tbl[i].ill) begin
            miscompares++;
            $display("FAIL %s illegal pulses: got %0d want %0d", tbl[i].name, ill,
                     tbl[i].ill);
         end
      end

      // sw that never completes: halt after TIMEOUT MEM cycles, sticky until reset.
      do_reset();
      run_instr(6'h2B, 6'h00, 1'b0, 0, 1000, "sw_timeout", cyc, regw, ill);
      for (int i = 0; i < 20; i++)
         step(P_HALT, K_SW, 1'($urandom), 1'($urandom), 1'($urandom), "halt_hold");
      check_ret("sw_timeout");
      do_reset();

      // Counter wrap with 16 ori.
      for (int i = 0; i < 16; i++) begin
         run_instr(6'h0D, 6'h00, 1'b0, 0, 0, "ori_wrap", cyc, regw, ill);
         check_ret("ori_wrap");
      end
      vectors++;
      if (retired !== 4'd0) begin
         miscompares++;
         $display("FAIL wrap: got %0d want 0", retired);
      end

      // Asynchronous reset while lw sits in MEM.
      opcode = 6'h23; func = 6'h00;
      step(P_FETCH, K_LW, 1'b0, 1'b1, 1'b0, "lw_abort");
      step(P_DEC, K_LW, 1'b0, 1'b0, 1'b0, "lw_abort");
      step(P_EXEC, K_LW, 1'b0, 1'b0, 1'b0, "lw_abort");
      step(P_MEM, K_LW, 1'b0, 1'b0, 1'b0, "lw_abort");
      #1;
      reset_n = 1'b0;
      #1;
      vectors += 2;
      if (state !== 3'd0) begin
         miscompares++;
         $display("FAIL async_reset state: got %0d want 0", state);
      end
      if (reg_write !== 1'b0 || dmem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset enables: got rw=%b dreq=%b want 0 0", reg_write, dmem_req);
      end
      @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 3; i++) step(P_FETCH, K_LW, 1'b0, 1'b0, 1'b1, "after_abort");
      check_ret("after_abort");

      // Randomized instruction stream against the model.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            op = legal_ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
               0: fn = 6'h21;
               1: fn = 6'h23;
               2: fn = 6'h08;
               default: fn = 6'($urandom);
            endcase
         end else begin
            op = 6'($urandom);
            fn = 6'($urandom);
         end
         k = cls_of(op, fn);
         run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 5),
                   "random", cyc, regw, ill);
         check_ret("random");
         if (model_halt) begin
            for (int i = 0; i < 3; i++)
               step(P_HALT, k, 1'($urandom), 1'($urandom), 1'($urandom), "random_halt");
            do_reset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
